mac_dot_sched: RTL and testbench

Two-requester scheduler and sequencer for a shared signed multiply-accumulate datapath. Each requester streams a burst of signed operand pairs (a, b) ending with a last flag. The block grants the MAC to one requester per burst with round-robin fairness, clears the accumulator at burst start, and drains the multiplier pipeline. It returns the dot product, sample count and requester ID on a result handshake. It sits between operand producers (filter taps, correlators) and the consumer of dot-product results.

---
 rtl/mac_dot_sched_if.sv | 50 +++++
 rtl/mac_dot_sched.sv | 163 ++++++++++++++++
 tb/tb_mac_dot_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_sched_if.sv
// mac_dot_sched_if
// Bundles the two-requester sample stream and the result stream of the
// shared signed MAC scheduler.
//
// Handshake semantics (both streams): a transfer happens on a rising clk
// edge where valid and ready are both 1. Sample streams are per requester
// (bit i of s_valid/s_ready/s_last belongs to requester i).
//
// Signals:
//   s_valid[1:0]  producer -> scheduler  per-requester sample valid
//   s_ready[1:0]  scheduler -> producer  per-requester sample ready
//   s_last[1:0]   producer -> scheduler  last sample of burst
//   s_a, s_b      producer -> scheduler  signed operands, requester i in slice i
//   m_valid       scheduler -> consumer  result valid
//   m_ready       consumer -> scheduler  result ready
//   m_data        scheduler -> consumer  signed dot product
//   m_id          scheduler -> consumer  requester that owned the burst
//   m_len         scheduler -> consumer  sample count modulo 2^LWIDTH
//   m_ovf         scheduler -> consumer  burst exceeded 2^LWIDTH samples
//
// Modports: slave = the scheduler, master = producers/consumer side.

interface mac_dot_sched_if #(
    parameter int AWIDTH = 8,
    parameter int BWIDTH = 8,
    parameter int LWIDTH = 8,
    parameter int OWIDTH = AWIDTH + BWIDTH + LWIDTH
) ();
    logic [1:0]          s_valid;
    logic [1:0]          s_ready;
    logic [1:0]          s_last;
    logic [2*AWIDTH-1:0] s_a;
    logic [2*BWIDTH-1:0] s_b;
    logic                m_valid;
    logic                m_ready;
    logic [OWIDTH-1:0]   m_data;
    logic                m_id;
    logic [LWIDTH-1:0]   m_len;
    logic                m_ovf;

    modport slave (
        input  s_valid, s_last, s_a, s_b, m_ready,
        output s_ready, m_valid, m_data, m_id, m_len, m_ovf
    );

    modport master (
        output s_valid, s_last, s_a, s_b, m_ready,
        input  s_ready, m_valid, m_data, m_id, m_len, m_ovf
    );
endinterface

// File: rtl/mac_dot_sched.sv
// mac_dot_sched
// Round-robin scheduler and sequencer for one shared signed multiply-
// accumulate datapath serving two burst requesters. A burst is granted in
// IDLE, streamed through a two-stage multiply pipeline in BURST, drained in
// DRAIN and presented on the result handshake in RESULT.
//
// Ports:
//   clk        rising-edge clock
//   sclr       synchronous active-high reset
//   bus        mac_dot_sched_if.slave (sample and result streams)
//   dbg_state  current FSM state (IDLE=0, BURST=1, DRAIN=2, RESULT=3)

module mac_dot_sched #(
    parameter int AWIDTH = 8,
    parameter int BWIDTH = 8,
    parameter int LWIDTH = 8,
    parameter int OWIDTH = AWIDTH + BWIDTH + LWIDTH
) (
    input  logic                  clk,
    input  logic                  sclr,
    mac_dot_sched_if.slave        bus,
    output logic [1:0]            dbg_state
);
    localparam int PW = AWIDTH + BWIDTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BURST  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    logic [1:0]               state;
    logic                     g;        // granted requester
    logic                     rr;       // round-robin preference
    logic [1:0]               dcnt;
    logic [LWIDTH-1:0]        cnt;
    logic                     started;  // at least one sample taken this burst
    logic                     ovf;

    logic                     v1, f1;
    logic signed [AWIDTH-1:0] a1;
    logic signed [BWIDTH-1:0] b1;
    logic                     v2, f2;
    logic signed [PW-1:0]     p2;
    logic signed [OWIDTH-1:0] acc;
    logic signed [OWIDTH-1:0] p2_ext;

    logic                     m_valid_r, m_id_r, m_ovf_r;
    logic [OWIDTH-1:0]        m_data_r;
    logic [LWIDTH-1:0]        m_len_r;

    logic                     s_valid_g, s_last_g, accept;
    logic [AWIDTH-1:0]        a_g;
    logic [BWIDTH-1:0]        b_g;

    // s_ready depends only on registered state, so there is no
    // combinational path from s_valid or m_ready to any output.
    assign bus.s_ready = (state == BURST) ? (g ? 2'b10 : 2'b01) : 2'b00;

    assign s_valid_g = g ? bus.s_valid[1] : bus.s_valid[0];
    assign s_last_g  = g ? bus.s_last[1]  : bus.s_last[0];
    assign a_g       = g ? bus.s_a[2*AWIDTH-1:AWIDTH] : bus.s_a[AWIDTH-1:0];
    assign b_g       = g ? bus.s_b[2*BWIDTH-1:BWIDTH] : bus.s_b[BWIDTH-1:0];
    assign accept    = (state == BURST) && s_valid_g;

    assign p2_ext = {{(OWIDTH-PW){p2[PW-1]}}, p2};

    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;
    assign bus.m_id    = m_id_r;
    assign bus.m_len   = m_len_r;
    assign bus.m_ovf   = m_ovf_r;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state     <= IDLE;
            g         <= 1'b0;
            rr        <= 1'b0;
            dcnt      <= 2'd0;
            cnt       <= '0;
            started   <= 1'b0;
            ovf       <= 1'b0;
            v1        <= 1'b0;
            f1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            v2        <= 1'b0;
            f2        <= 1'b0;
            p2        <= '0;
            acc       <= '0;
            m_valid_r <= 1'b0;
            m_id_r    <= 1'b0;
            m_ovf_r   <= 1'b0;
            m_data_r  <= '0;
            m_len_r   <= '0;
        end else begin
            // Stage 1: register accepted operands, tagging the first sample.
            v1 <= accept;
            if (accept) begin
                a1 <= a_g;
                b1 <= b_g;
                f1 <= !started;
            end
            // Stage 2: registered product.
            v2 <= v1;
            f2 <= f1;
            p2 <= a1 * b1;
            // The first product of a burst loads the accumulator, which
            // clears any previous burst without a separate clear cycle.
            if (v2) begin
                acc <= f2 ? p2_ext : acc + p2_ext;
            end

            case (state)
                IDLE: begin
                    if (bus.s_valid != 2'b00) begin
                        g       <= (bus.s_valid == 2'b11) ? rr : bus.s_valid[1];
                        state   <= BURST;
                        cnt     <= '0;
                        started <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        cnt     <= cnt + 1'b1;
                        started <= 1'b1;
                        // Counter at zero after a sample means it already
                        // wrapped at 2^LWIDTH; one more sample overflows.
                        if (started && cnt == '0) begin
                            ovf <= 1'b1;
                        end
                        if (s_last_g) begin
                            state <= DRAIN;
                            dcnt  <= 2'd0;
                        end
                    end
                end
                DRAIN: begin
                    // Two edges let the last product reach the accumulator;
                    // the third edge latches the result registers.
                    if (dcnt == 2'd2) begin
                        state     <= RESULT;
                        m_valid_r <= 1'b1;
                        m_data_r  <= acc;
                        m_id_r    <= g;
                        m_len_r   <= cnt;
                        m_ovf_r   <= ovf;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                default: begin
                    if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        rr        <= ~g;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_sched.sv
// tb_mac_dot_sched
// Self-checking bench for mac_dot_sched with AWIDTH=BWIDTH=8, LWIDTH=2
// (OWIDTH=18) so that the sample-count wrap and overflow are reached with
// short bursts. Expected results come from a burst-level model: the signed
// sum of products wrapped to 18 bits, the count modulo 4 and count > 4.

module tb_mac_dot_sched;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int LW = 2;
    localparam int OW = AW + BW + LW;
    localparam int EW = 1 + LW + OW;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
        logic [3:0] gap;
    } smp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic sclr;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mac_dot_sched_if #(.AWIDTH(AW), .BWIDTH(BW), .LWIDTH(LW)) bus ();

    mac_dot_sched #(.AWIDTH(AW), .BWIDTH(BW), .LWIDTH(LW)) dut (
        .clk       (clk),
        .sclr      (sclr),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- driver state ----------------
    logic       sv [2];
    logic       sl [2];
    logic [7:0] sa [2];
    logic [7:0] sb [2];
    logic       m_ready;
    bit         rand_ready;
    smp_t       drv_q [2][$];
    int         gapc [2];
    bit         ld [2];
    int         fires [2];

    assign bus.s_valid = {sv[1], sv[0]};
    assign bus.s_last  = {sl[1], sl[0]};
    assign bus.s_a     = {sa[1], sa[0]};
    assign bus.s_b     = {sb[1], sb[0]};
    assign bus.m_ready = m_ready;

    // ---------------- model / scoreboard ----------------
    logic [EW-1:0] exp_q [2][$];
    int            lat_q [$];
    longint        gen_sum [2];
    int            gen_n [2];

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] res_data;
    logic [LW-1:0] res_len;
    logic          res_id, res_ovf;
    int            id_log [$];
    longint        data_log [$];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Queue one sample for requester i and, on the last sample, the result
    // the burst must produce.
    task automatic add_pair(input int i, input int a, input int b,
                            input bit last, input int gap);
        smp_t          s;
        longint        t;
        logic [EW-1:0] e;
        s.a = 8'(a);
        s.b = 8'(b);
        s.last = last;
        s.gap = 4'(gap);
        drv_q[i].push_back(s);
        gen_sum[i] += longint'(a * b);
        gen_n[i]++;
        if (last) begin
            t = gen_sum[i];
            e = {(gen_n[i] > 4) ? 1'b1 : 1'b0, 2'(gen_n[i] % 4), t[OW-1:0]};
            exp_q[i].push_back(e);
            gen_sum[i] = 0;
            gen_n[i] = 0;
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 2; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
            sv[i] = 1'b0;
            ld[i] = 1'b0;
            gen_sum[i] = 0;
            gen_n[i] = 0;
        end
        lat_q.delete();
    endtask

    // One clock: observe handshakes mid-cycle, then drive the next values.
    task automatic cycle();
        bit f [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            f[i] = sv[i] && bus.s_ready[i];
            if (f[i]) begin
                fires[i]++;
                if (drv_q[i][0].last) lat_q.push_back(cyc + 4);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (f[i]) begin
                void'(drv_q[i].pop_front());
                ld[i] = 1'b0;
            end
            if (drv_q[i].size() > 0) begin
                if (!ld[i]) begin
                    gapc[i] = int'(drv_q[i][0].gap);
                    ld[i] = 1'b1;
                end
                if (gapc[i] > 0) begin
                    gapc[i]--;
                    sv[i] = 1'b0;
                    sl[i] = 1'($urandom_range(0, 1));
                end else begin
                    sv[i] = 1'b1;
                    sa[i] = drv_q[i][0].a;
                    sb[i] = drv_q[i][0].b;
                    sl[i] = drv_q[i][0].last;
                end
            end else begin
                sv[i] = 1'b0;
                sl[i] = 1'($urandom_range(0, 1));
                sa[i] = 8'($urandom_range(0, 255));
            end
        end
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((drv_q[0].size() + drv_q[1].size() + exp_q[0].size()
                + exp_q[1].size()) != 0 || bus.m_valid) begin
            if (n >= limit) begin
                checks++;
                errors++;
                $display("FAIL timeout: %0d cycles waiting for idle, limit %0d", n, limit);
                flush();
                return;
            end
            cycle();
            n++;
        end
    endtask

    // ---------------- compare process ----------------
    logic              pv = 1'b0;
    logic              pr = 1'b0;
    logic [EW:0]       held;
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        checks++;
        if ((bus.m_valid && bus.s_ready != 2'b00) || bus.s_ready == 2'b11) begin
            errors++;
            $display("FAIL s_ready: got %b with m_valid=%b, required one-hot0 and 00 in result",
                     bus.s_ready, bus.m_valid);
        end
        if (bus.m_valid) begin
            got = {bus.m_ovf, bus.m_len, bus.m_data};
            if (!pv || pr) begin
                res_data = bus.m_data;
                res_len  = bus.m_len;
                res_id   = bus.m_id;
                res_ovf  = bus.m_ovf;
                id_log.push_back(int'(bus.m_id));
                data_log.push_back(longint'($signed(bus.m_data)));
                checks++;
                if (exp_q[bus.m_id].size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected result id %0d data %0d, none required",
                             bus.m_id, $signed(bus.m_data));
                end else begin
                    e = exp_q[bus.m_id].pop_front();
                    if (e != got) begin
                        errors++;
                        $display("FAIL result id %0d: got ovf/len/data %0d/%0d/%0d, required %0d/%0d/%0d",
                                 bus.m_id, got[EW-1], got[EW-2:OW], $signed(got[OW-1:0]),
                                 e[EW-1], e[EW-2:OW], $signed(e[OW-1:0]));
                    end
                end
                checks++;
                if (lat_q.size() == 0) begin
                    errors++;
                    $display("FAIL latency: m_valid rose at edge %0d with no last accept", cyc);
                end else begin
                    int t;
                    t = lat_q.pop_front();
                    if (t != cyc) begin
                        errors++;
                        $display("FAIL latency: m_valid rose at edge %0d, required %0d", cyc, t);
                    end
                end
            end else begin
                checks++;
                if ({got, bus.m_id} != held) begin
                    errors++;
                    $display("FAIL stall: outputs %h changed, required %h", {got, bus.m_id}, held);
                end
            end
            held = {got, bus.m_id};
        end
        pv = bus.m_valid;
        pr = m_ready;
    end

    // ---------------- stimulus ----------------
    initial begin
        int base, n;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; sl[i] = 1'b0; sa[i] = '0; sb[i] = '0;
            gapc[i] = 0; ld[i] = 1'b0; fires[i] = 0;
            gen_sum[i] = 0; gen_n[i] = 0;
        end
        m_ready = 1'b1;
        rand_ready = 1'b0;
        sclr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sclr = 1'b0;
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_id", bus.m_id, 0);
        check("rst_m_len", bus.m_len, 0);
        check("rst_m_ovf", bus.m_ovf, 0);

        // Both requesters continuously asserting, 2-sample bursts.
        id_log.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                add_pair(i, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1'b0, 0);
                add_pair(i, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1'b1, 0);
            end
        end
        wait_idle(300);
        check("rr_count", id_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (id_log.size() > k) check("rr_id", id_log[k], k % 2);
        end

        // Single burst on requester 0.
        add_pair(0, 3, 4, 1'b0, 0);
        add_pair(0, -2, 5, 1'b0, 0);
        add_pair(0, 7, -1, 1'b1, 0);
        wait_idle(100);
        check("t1_data", $signed(res_data), -5);
        check("t1_len", res_len, 3);
        check("t1_id", res_id, 0);
        check("t1_ovf", res_ovf, 0);

        // Operand extremes, then accumulator clear on the next burst.
        for (int k = 0; k < 4; k++) add_pair(0, -128, -128, k == 3, 0);
        wait_idle(100);
        check("ext_data", $signed(res_data), 65536);
        add_pair(0, 127, -128, 1'b1, 0);
        wait_idle(100);
        check("ext_clear", $signed(res_data), -16256);
        check("ext_len", res_len, 1);

        // Bubbles mid-burst and a 5-cycle result stall.
        m_ready = 1'b0;
        add_pair(1, 5, 6, 1'b0, 0);
        add_pair(1, -3, 4, 1'b0, 2);
        add_pair(1, 2, 2, 1'b1, 0);
        n = 0;
        while (!bus.m_valid && n < 100) begin
            cycle();
            n++;
        end
        check("stall_seen", bus.m_valid, 1);
        add_pair(0, 1, 2, 1'b1, 0);
        repeat (5) cycle();
        check("stall_data", $signed(res_data), 22);
        check("stall_id", res_id, 1);
        check("stall_len", res_len, 3);
        check("stall_valid", bus.m_valid, 1);
        m_ready = 1'b1;
        wait_idle(100);
        check("after_stall_data", $signed(res_data), 2);
        check("after_stall_id", res_id, 0);

        // Count wrap: exactly 2^LW samples, then one more.
        for (int k = 0; k < 4; k++) add_pair(0, 1, 1, k == 3, 0);
        wait_idle(100);
        check("wrap_len", res_len, 0);
        check("wrap_ovf", res_ovf, 0);
        check("wrap_data", $signed(res_data), 4);
        for (int k = 0; k < 5; k++) add_pair(0, 1, 1, k == 4, 0);
        wait_idle(100);
        check("ovf_len", res_len, 1);
        check("ovf_ovf", res_ovf, 1);
        check("ovf_data", $signed(res_data), 5);

        // Reset after two samples of a burst.
        base = fires[0];
        add_pair(0, 9, 9, 1'b0, 0);
        add_pair(0, 9, 9, 1'b0, 0);
        add_pair(0, 9, 9, 1'b1, 6);
        n = 0;
        while (fires[0] - base < 2 && n < 100) begin
            cycle();
            n++;
        end
        check("rst_mid_accepts", fires[0] - base, 2);
        sclr = 1'b1;
        flush();
        cycle();
        sclr = 1'b0;
        check("rst2_m_valid", bus.m_valid, 0);
        check("rst2_s_ready", bus.s_ready, 0);
        check("rst2_m_data", bus.m_data, 0);
        check("rst2_m_id", bus.m_id, 0);
        check("rst2_m_len", bus.m_len, 0);
        check("rst2_m_ovf", bus.m_ovf, 0);
        id_log.delete();
        data_log.delete();
        add_pair(0, 2, 3, 1'b0, 0);
        add_pair(0, 1, 1, 1'b1, 0);
        add_pair(1, 4, 4, 1'b1, 0);
        wait_idle(100);
        check("post_rst_count", id_log.size(), 2);
        if (id_log.size() > 0) check("post_rst_first_id", id_log[0], 0);
        if (data_log.size() > 0) check("post_rst_first_data", data_log[0], 7);

        // Randomized bursts from both requesters with random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int i, len;
            i = $urandom_range(0, 1);
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                add_pair(i, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                         j == len - 1,
                         ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
        end
        n = 0;
        while (drv_q[0].size() + drv_q[1].size() != 0 && n < 4000) begin
            cycle();
            n++;
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        wait_idle(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
